rv_muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit, parametrised in WIDTH. Replaces the single-cycle MUL/DIV
//  ALU path of the single-cycle core. Implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//  per the RISC-V M spec. Sits beside the ALU; the core stalls on req_ready/resp_valid.

---
 rtl/rv_muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with sign fix-up on the final step.
module rv_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             accept, is_div, a_signed, b_signed, sa, sb;
    logic             div_by_zero, div_ovf, div_take;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_hi;
    logic [WIDTH-1:0] div_diff;
    logic [AW-1:0]    mul_next, div_next, step_acc, prod_s;
    logic [WIDTH-1:0] quo_s, rem_s, final_result;

    always_comb begin
        accept      = req_valid && (state_q == IDLE);
        is_div      = funct3[2];
        a_signed    = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed    = is_div ? ~funct3[0] : ~funct3[1];
        sa          = a_signed & op_a[WIDTH-1];
        sb          = b_signed & op_b[WIDTH-1];
        a_mag       = sa ? -op_a : op_a;
        b_mag       = sb ? -op_b : op_b;
        div_by_zero = is_div && (op_b == '0);
        div_ovf     = is_div && !funct3[0] && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
    end

    // acc holds {partial, operand}: for multiply the low half is the shrinking multiplier,
    // for divide it is the dividend shifting out while quotient bits shift in.
    always_comb begin
        mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[AW-1:1]};
        div_hi   = acc_q[AW-1:WIDTH-1];
        div_take = div_hi >= {1'b0, opnd_q};
        div_diff = div_hi[WIDTH-1:0] - opnd_q;
        div_next = div_take ? {div_diff, acc_q[WIDTH-2:0], 1'b1} : {acc_q[AW-2:0], 1'b0};
        step_acc = op_q[2] ? div_next : mul_next;
        prod_s   = neg_q ? -step_acc : step_acc;
        quo_s    = neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
        rem_s    = rneg_q ? -step_acc[AW-1:WIDTH] : step_acc[AW-1:WIDTH];
        if (op_q[2]) begin
            final_result = op_q[1] ? rem_s : quo_s;
        end else begin
            final_result = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[AW-1:WIDTH];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        opnd_d       = opnd_q;
        acc_d        = acc_q;
        neg_d        = neg_q;
        rneg_d       = rneg_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        case (state_q)
            IDLE: begin
                if (accept && !kill) begin
                    op_d   = funct3;
                    cnt_d  = '0;
                    neg_d  = sa ^ sb;
                    rneg_d = sa;
                    if (div_by_zero) begin
                        result_d     = funct3[1] ? op_a : '1;
                        resp_valid_d = 1'b1;
                        state_d      = DONE;
                    end else if (div_ovf) begin
                        result_d     = funct3[1] ? '0 : op_a;
                        resp_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d = CALC;
                        acc_d   = {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
                        opnd_d  = is_div ? b_mag : a_mag;
                    end
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        result_d     = final_result;
                        resp_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (kill || resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            opnd_q       <= '0;
            acc_q        <= '0;
            neg_q        <= 1'b0;
            rneg_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            opnd_q       <= opnd_d;
            acc_q        <= acc_d;
            neg_q        <= neg_d;
            rneg_q       <= rneg_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign result     = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit (WIDTH=32): directed vector table, random ops
// against a plain-arithmetic reference model, and handshake/kill/reset sequences.
module tb_rv_muldiv_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    rv_muldiv_unit #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .funct3     (funct3),
        .op_a       (op_a),
        .op_b       (op_b),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Hard stop in case something wedges outside the bounded waits below.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // RISC-V M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: begin sp = sa * sb; return sp[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                sp = sa % sb; return sp[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 32'd0) return 1;
        if (f[2] && !f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for the response; the response is left pending.
    // lat counts edges after the accept edge until resp_valid is first seen at an edge.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat);
        int spin = 0;
        @(negedge clock);
        while (!req_ready && spin < 100) begin
            @(negedge clock);
            spin++;
        end
        funct3    = f;
        op_a      = a;
        op_b      = b;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        funct3    = 3'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        res = result;
    endtask

    task automatic releaseResponse(input string name);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        checkOutput({name, "_valid_drop"}, 32'(resp_valid), 32'd0);
        checkOutput({name, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic watchQuiet(input string name, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (resp_valid) seen++;
        end
        checkOutput(name, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] res, exp, a, b;
        logic [2:0]  f;
        int          lat;

        reset      = 1'b1;
        req_valid  = 1'b0;
        funct3     = 3'd0;
        op_a       = 32'd0;
        op_b       = 32'd0;
        kill       = 1'b0;
        resp_ready = 1'b0;

        // Directed vectors with their expected results and response latency.
        vecs.push_back('{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
        vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33});
        vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
        vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
        vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
        vecs.push_back('{3'd5, 32'd7,        32'd2,        32'd3,        33});
        vecs.push_back('{3'd7, 32'd7,        32'd2,        32'd1,        33});
        vecs.push_back('{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{3'd6, 32'd5,        32'd0,        32'd5,        1});
        vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1});
        vecs.push_back('{3'd7, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1});
        vecs.push_back('{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33});

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_result", result, 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, res, lat);
            checkOutput($sformatf("vec%0d_result", i), res, vecs[i].exp);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            releaseResponse($sformatf("vec%0d", i));
        end

        // Random operations with a bias towards the special operand patterns.
        for (int n = 0; n < 150; n++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       begin a = $urandom; b = 32'd0; end
                1:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2:       begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
                3:       begin a = -32'($urandom_range(0, 50)); b = -32'($urandom_range(1, 9)); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            exp = refModel(f, a, b);
            applyStimulus(f, a, b, res, lat);
            checkOutput($sformatf("rand%0d_f%0d_%h_%h", n, f, a, b), res, exp);
            checkOutput($sformatf("rand%0d_latency", n), 32'(lat), 32'(refLatency(f, a, b)));
            resp_ready = 1'b1;
            @(negedge clock);
            resp_ready = 1'b0;
        end

        // Response held with resp_ready low; a competing request must not be taken.
        applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
        checkOutput("hold_first", res, 32'hFFFFFFFE);
        funct3    = 3'd0;
        op_a      = 32'd2;
        op_b      = 32'd2;
        req_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checkOutput($sformatf("hold%0d_result", c), result, 32'hFFFFFFFE);
            checkOutput($sformatf("hold%0d_valid", c), 32'(resp_valid), 32'd1);
            checkOutput($sformatf("hold%0d_req_ready", c), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        releaseResponse("hold");

        // kill in the fifth CALC cycle.
        @(negedge clock);
        funct3    = 3'd0;
        op_a      = 32'd5;
        op_b      = 32'd6;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (4) @(negedge clock);
        kill = 1'b1;
        @(negedge clock);
        kill = 1'b0;
        checkOutput("kill_req_ready", 32'(req_ready), 32'd1);
        checkOutput("kill_busy", 32'(busy), 32'd0);
        checkOutput("kill_resp_valid", 32'(resp_valid), 32'd0);
        watchQuiet("kill_no_resp", 40);

        // reset in the twentieth CALC cycle.
        funct3    = 3'd5;
        op_a      = 32'd1000;
        op_b      = 32'd7;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        watchQuiet("midrst_no_resp", 40);

        applyStimulus(3'd0, 32'd3, 32'd4, res, lat);
        checkOutput("after_abort_mul", res, 32'd12);
        checkOutput("after_abort_latency", 32'(lat), 32'd33);
        releaseResponse("after_abort");

        // kill together with an accept in IDLE discards the request.
        funct3    = 3'd0;
        op_a      = 32'd9;
        op_b      = 32'd9;
        req_valid = 1'b1;
        kill      = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        kill      = 1'b0;
        checkOutput("idlekill_req_ready", 32'(req_ready), 32'd1);
        checkOutput("idlekill_busy", 32'(busy), 32'd0);
        watchQuiet("idlekill_no_resp", 40);

        // kill while a response is pending drops it.
        applyStimulus(3'd4, 32'd5, 32'd0, res, lat);
        checkOutput("donekill_result", res, 32'hFFFFFFFF);
        kill = 1'b1;
        @(negedge clock);
        kill = 1'b0;
        checkOutput("donekill_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("donekill_req_ready", 32'(req_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
